// File: rtl/sample_reader_pkg.sv
// sample_reader_pkg: shared types, constants and checksum helpers for the
// sample reader. The CSUM state exists only when SAMPLE_READER_CHECKSUM_EN
// is defined.
package sample_reader_pkg;

  localparam logic [7:0] SR_HEADER = 8'hA5;
  localparam logic [7:0] SR_CMD    = 8'h22;

  typedef enum logic [2:0] {
    SR_IDLE  = 3'd0,
    SR_HDR   = 3'd1,
    SR_LEN   = 3'd2,
    SR_FETCH = 3'd3,
    SR_SEND  = 3'd4,
    SR_FIN   = 3'd5
`ifdef SAMPLE_READER_CHECKSUM_EN
    ,
    SR_CSUM  = 3'd6
`endif
  } sr_state_t;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_WAIT = 2'd1,
    TX_BUSY = 2'd2
  } sr_tx_state_t;

  // Running sum of sample bytes, modulo 256.
  function automatic logic [7:0] sr_csum_add(input logic [7:0] sum, input logic [7:0] sample);
    return sum + sample;
  endfunction

  // Two's complement of the sum, so samples plus checksum total 0 mod 256.
  function automatic logic [7:0] sr_csum_final(input logic [7:0] sum);
    return 8'h00 - sum;
  endfunction

endpackage

// File: rtl/sample_reader_if.sv
// sample_reader_if: activate/done handshake, sample memory read port and
// uart_tx byte interface of the sample reader. The master side is the reader.
interface sample_reader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) ();

  logic                  activate;
  logic                  done;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_oe;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [7:0]            tx_data;
  logic                  tx_start;
  logic                  tx_active;
  logic                  tx_done;

  modport master (
    input  activate, mem_data, tx_active, tx_done,
    output done, mem_addr, mem_oe, tx_data, tx_start
  );

  modport slave (
    output activate, mem_data, tx_active, tx_done,
    input  done, mem_addr, mem_oe, tx_data, tx_start
  );

endinterface

// File: rtl/sample_reader_tx_seq.sv
// sr_tx_seq: byte-send handshake towards the shared uart_tx. A request
// latches the byte into tx_data, the start pulse waits for tx_active=0, and
// ack follows the tx_done that belongs to this block's own start pulse.
module sr_tx_seq
  import sample_reader_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req,
  input  logic [7:0] i_byte,
  input  logic       i_tx_active,
  input  logic       i_tx_done,
  output logic       o_ack,
  output logic [7:0] o_tx_data,
  output logic       o_tx_start
);

  sr_tx_state_t r_state;
  logic [7:0]   r_tx_data;
  logic         r_tx_start;
  logic         r_ack;

  // Send sequencer: latch byte, gate on tx_active, single start pulse, ack on tx_done.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= TX_IDLE;
      r_tx_data  <= 8'h00;
      r_tx_start <= 1'b0;
      r_ack      <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_ack      <= 1'b0;
      case (r_state)
        TX_IDLE: begin
          if (i_req) begin
            r_tx_data <= i_byte;
            r_state   <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (!i_tx_active) begin
            r_tx_start <= 1'b1;
            r_state    <= TX_BUSY;
          end
        end
        TX_BUSY: begin
          // A tx_done in the same cycle as our own start pulse cannot be ours.
          if (i_tx_done && !r_tx_start) begin
            r_ack   <= 1'b1;
            r_state <= TX_IDLE;
          end
        end
        default: begin
          r_state <= TX_IDLE;
        end
      endcase
    end
  end

  assign o_ack      = r_ack;
  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;

endmodule

// File: rtl/sample_reader.sv
// sample_reader: on activate, streams header, length, SAMPLE_COUNT samples
// (address 0 upward) and, when SAMPLE_READER_CHECKSUM_EN is defined, a
// checksum byte over the shared uart_tx. done is held until activate falls.
// DATA_WIDTH must be 8 (the UART byte width).
module sample_reader
  import sample_reader_pkg::*;
#(
  parameter int         ADDR_WIDTH   = 8,
  parameter int         DATA_WIDTH   = 8,
  parameter int         SAMPLE_COUNT = 256,
  parameter logic [7:0] HEADER       = SR_HEADER
) (
  input  logic              clk_50mhz,
  input  logic              reset,
  sample_reader_if.master   bus
);

  // Index carries one extra bit so SAMPLE_COUNT = 2**ADDR_WIDTH never wraps early.
  localparam logic [ADDR_WIDTH:0] LAST_INDEX = (ADDR_WIDTH + 1)'(SAMPLE_COUNT - 1);
  localparam logic [7:0]          LEN_BYTE   = 8'(SAMPLE_COUNT - 1);

  sr_state_t             r_state;
  logic [ADDR_WIDTH:0]   r_index;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_oe;
  logic                  r_done;
  logic                  r_req;
`ifdef SAMPLE_READER_CHECKSUM_EN
  logic [7:0]            r_csum;
`endif

  logic [ADDR_WIDTH:0]   w_index_next;
  logic [DATA_WIDTH-1:0] w_sample;
  logic [7:0]            w_req_byte;
  logic                  w_req;
  logic                  w_ack;

  assign w_index_next = r_index + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign w_sample     = bus.mem_data;
  // A request is only issued while the block still owns the UART.
  assign w_req        = r_req & bus.activate;

  // Byte offered to the send sequencer in the current state.
  always_comb begin
    w_req_byte = 8'h00;
    case (r_state)
      SR_HDR:   w_req_byte = HEADER;
      SR_LEN:   w_req_byte = LEN_BYTE;
      SR_FETCH: w_req_byte = w_sample;
`ifdef SAMPLE_READER_CHECKSUM_EN
      SR_CSUM:  w_req_byte = sr_csum_final(r_csum);
`endif
      default:  w_req_byte = 8'h00;
    endcase
  end

  // Frame FSM: sequencing, sample index, memory read port, checksum and done.
  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      r_state    <= SR_IDLE;
      r_index    <= '0;
      r_mem_addr <= '0;
      r_mem_oe   <= 1'b0;
      r_done     <= 1'b0;
      r_req      <= 1'b0;
`ifdef SAMPLE_READER_CHECKSUM_EN
      r_csum     <= 8'h00;
`endif
    end else begin
      r_req <= 1'b0;
      case (r_state)
        SR_IDLE: begin
          r_index    <= '0;
          r_mem_addr <= '0;
          r_mem_oe   <= 1'b0;
          r_done     <= 1'b0;
`ifdef SAMPLE_READER_CHECKSUM_EN
          r_csum     <= 8'h00;
`endif
          if (bus.activate) begin
            r_req   <= 1'b1;
            r_state <= SR_HDR;
          end
        end
        SR_HDR: begin
          if (r_req && !bus.activate) begin
            r_state <= SR_IDLE;
          end else if (w_ack) begin
            if (!bus.activate) begin
              r_state <= SR_IDLE;
            end else begin
              r_req   <= 1'b1;
              r_state <= SR_LEN;
            end
          end
        end
        SR_LEN: begin
          if (r_req && !bus.activate) begin
            r_state <= SR_IDLE;
          end else if (w_ack) begin
            if (!bus.activate) begin
              r_state <= SR_IDLE;
            end else begin
              r_mem_oe   <= 1'b1;
              r_mem_addr <= r_index[ADDR_WIDTH-1:0];
              r_req      <= 1'b1;
              r_state    <= SR_FETCH;
            end
          end
        end
        SR_FETCH: begin
          // mem_data is captured into tx_data by the sequencer at this edge.
          r_mem_oe <= 1'b0;
          if (!bus.activate) begin
            r_state <= SR_IDLE;
          end else begin
            r_state <= SR_SEND;
          end
        end
        SR_SEND: begin
          if (w_ack) begin
`ifdef SAMPLE_READER_CHECKSUM_EN
            r_csum <= sr_csum_add(r_csum, bus.tx_data);
`endif
            if (!bus.activate) begin
              r_state <= SR_IDLE;
            end else if (r_index == LAST_INDEX) begin
`ifdef SAMPLE_READER_CHECKSUM_EN
              r_req   <= 1'b1;
              r_state <= SR_CSUM;
`else
              r_done  <= 1'b1;
              r_state <= SR_FIN;
`endif
            end else begin
              r_index    <= w_index_next;
              r_mem_oe   <= 1'b1;
              r_mem_addr <= w_index_next[ADDR_WIDTH-1:0];
              r_req      <= 1'b1;
              r_state    <= SR_FETCH;
            end
          end
        end
`ifdef SAMPLE_READER_CHECKSUM_EN
        SR_CSUM: begin
          if (r_req && !bus.activate) begin
            r_state <= SR_IDLE;
          end else if (w_ack) begin
            if (!bus.activate) begin
              r_state <= SR_IDLE;
            end else begin
              r_done  <= 1'b1;
              r_state <= SR_FIN;
            end
          end
        end
`endif
        SR_FIN: begin
          if (!bus.activate) begin
            r_done  <= 1'b0;
            r_state <= SR_IDLE;
          end
        end
        default: begin
          r_state <= SR_IDLE;
        end
      endcase
    end
  end

  sr_tx_seq u_tx_seq (
    .i_clk       (clk_50mhz),
    .i_rst_n     (reset),
    .i_req       (w_req),
    .i_byte      (w_req_byte),
    .i_tx_active (bus.tx_active),
    .i_tx_done   (bus.tx_done),
    .o_ack       (w_ack),
    .o_tx_data   (bus.tx_data),
    .o_tx_start  (bus.tx_start)
  );

  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_oe   = r_mem_oe;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_sample_reader.sv
// tb_sample_reader: directed bench. Instance A has 4 samples {10,20,30,40},
// instance B has 256 samples mem[i]=i. A small UART model records each
// started byte and answers with tx_done a fixed number of cycles later.
module tb_sample_reader;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  logic hold_a;

  always #10 clk = ~clk;

  sample_reader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus_a ();
  sample_reader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus_b ();

  sample_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .SAMPLE_COUNT(4), .HEADER(8'hA5)) dut_a (
    .clk_50mhz (clk),
    .reset     (rst_a),
    .bus       (bus_a.master)
  );

  sample_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .SAMPLE_COUNT(256), .HEADER(8'hA5)) dut_b (
    .clk_50mhz (clk),
    .reset     (rst_b),
    .bus       (bus_b.master)
  );

  // Sample memories with asynchronous read.
  logic [7:0] mem_a [0:255];
  logic [7:0] mem_b [0:255];
  assign bus_a.mem_data = mem_a[bus_a.mem_addr];
  assign bus_b.mem_data = mem_b[bus_b.mem_addr];

  // UART models: byte time of 7 cycles after the start pulse.
  logic [7:0] q_a [$];
  logic [7:0] q_b [$];
  logic [3:0] cnt_a, cnt_b;
  logic       done_a, done_b;
  int         starts_a = 0;
  int         starts_b = 0;

  assign bus_a.tx_active = (cnt_a != 4'd0) || hold_a;
  assign bus_a.tx_done   = done_a;
  assign bus_b.tx_active = (cnt_b != 4'd0);
  assign bus_b.tx_done   = done_b;

  // UART model for instance A.
  always @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      cnt_a  <= 4'd0;
      done_a <= 1'b0;
    end else begin
      done_a <= 1'b0;
      if (cnt_a != 4'd0) begin
        cnt_a <= cnt_a - 4'd1;
        if (cnt_a == 4'd1) done_a <= 1'b1;
      end else if (bus_a.tx_start) begin
        cnt_a <= 4'd6;
        q_a.push_back(bus_a.tx_data);
      end
    end
  end

  // UART model for instance B.
  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_b  <= 4'd0;
      done_b <= 1'b0;
    end else begin
      done_b <= 1'b0;
      if (cnt_b != 4'd0) begin
        cnt_b <= cnt_b - 4'd1;
        if (cnt_b == 4'd1) done_b <= 1'b1;
      end else if (bus_b.tx_start) begin
        cnt_b <= 4'd6;
        q_b.push_back(bus_b.tx_data);
      end
    end
  end

  // Count every start pulse cycle, busy or not.
  always @(posedge clk) begin
    if (bus_a.tx_start) starts_a <= starts_a + 1;
    if (bus_b.tx_start) starts_b <= starts_b + 1;
  end

  int n_total = 0;
  int n_bad   = 0;
  logic [7:0] exp_a [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done_a(input int budget);
    int k;
    k = 0;
    while (bus_a.done !== 1'b1 && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_eq("a_done_seen", {31'd0, bus_a.done}, 32'd1);
  endtask

  task automatic wait_bytes_a(input int n, input int budget);
    int k;
    k = 0;
    while (q_a.size() < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_eq("a_bytes_reached", q_a.size(), n);
  endtask

  task automatic check_frame_a(input string tag, input int base);
    check_eq({tag, "_len"}, q_a.size() - base, exp_a.size());
    for (int i = 0; i < exp_a.size(); i++) begin
      check_eq($sformatf("%s_byte%0d", tag, i), {24'd0, q_a[base + i]}, {24'd0, exp_a[i]});
    end
  endtask

  initial begin
    int base;
    int sbase;
    int k;
    exp_a = '{8'hA5, 8'h03, 8'h0A, 8'h14, 8'h1E, 8'h28};
`ifdef SAMPLE_READER_CHECKSUM_EN
    // 0x0A+0x14+0x1E+0x28 = 0x64, two's complement 0x9C
    exp_a.push_back(8'h9C);
`endif
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'(i);
    end
    mem_a[0] = 8'd10;
    mem_a[1] = 8'd20;
    mem_a[2] = 8'd30;
    mem_a[3] = 8'd40;
    rst_a = 1'b0;
    rst_b = 1'b0;
    hold_a = 1'b0;
    bus_a.activate = 1'b0;
    bus_b.activate = 1'b0;
    cycles(3);

    // Reset state
    check_eq("rst_done", {31'd0, bus_a.done}, 32'd0);
    check_eq("rst_tx_start", {31'd0, bus_a.tx_start}, 32'd0);
    check_eq("rst_mem_oe", {31'd0, bus_a.mem_oe}, 32'd0);
    check_eq("rst_mem_addr", {24'd0, bus_a.mem_addr}, 32'd0);
    check_eq("rst_tx_data", {24'd0, bus_a.tx_data}, 32'd0);
    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    cycles(2);
    check_eq("idle_no_start", starts_a, 0);

    // 1: basic 4-sample frame
    base  = q_a.size();
    sbase = starts_a;
    bus_a.activate = 1'b1;
    wait_done_a(2000);
    check_frame_a("t1", base);
    check_eq("t1_starts", starts_a - sbase, exp_a.size());
    check_eq("t1_mem_oe_low", {31'd0, bus_a.mem_oe}, 32'd0);

    // 6: done held while activate stays high, no re-send
    sbase = starts_a;
    cycles(50);
    check_eq("t6_done_held", {31'd0, bus_a.done}, 32'd1);
    check_eq("t6_no_resend", starts_a - sbase, 0);
    @(negedge clk);
    bus_a.activate = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t6_done_drop", {31'd0, bus_a.done}, 32'd0);
    cycles(3);

    // 4: drop activate after the header starts
    base  = q_a.size();
    sbase = starts_a;
    @(negedge clk);
    bus_a.activate = 1'b1;
    wait_bytes_a(base + 1, 200);
    @(negedge clk);
    bus_a.activate = 1'b0;
    cycles(60);
    check_eq("t4_bytes", q_a.size() - base, 1);
    check_eq("t4_hdr", {24'd0, q_a[base]}, 32'h0000_00A5);
    check_eq("t4_starts", starts_a - sbase, 1);
    check_eq("t4_no_done", {31'd0, bus_a.done}, 32'd0);

    // 5: tx_active held high blocks the start pulse
    base  = q_a.size();
    sbase = starts_a;
    @(negedge clk);
    hold_a = 1'b1;
    bus_a.activate = 1'b1;
    cycles(500);
    check_eq("t5_blocked", starts_a - sbase, 0);
    @(negedge clk);
    hold_a = 1'b0;
    wait_done_a(2000);
    check_frame_a("t5", base);
    check_eq("t5_starts", starts_a - sbase, exp_a.size());
    @(negedge clk);
    bus_a.activate = 1'b0;
    cycles(3);

    // 3: reset while the 3rd sample is in flight, then restart
    base = q_a.size();
    @(negedge clk);
    bus_a.activate = 1'b1;
    wait_bytes_a(base + 5, 500);
    @(negedge clk);
    rst_a = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t3_tx_start", {31'd0, bus_a.tx_start}, 32'd0);
    check_eq("t3_mem_oe", {31'd0, bus_a.mem_oe}, 32'd0);
    check_eq("t3_mem_addr", {24'd0, bus_a.mem_addr}, 32'd0);
    check_eq("t3_tx_data", {24'd0, bus_a.tx_data}, 32'd0);
    check_eq("t3_done", {31'd0, bus_a.done}, 32'd0);
    @(negedge clk);
    rst_a = 1'b1;
    base  = q_a.size();
    sbase = starts_a;
    wait_done_a(2000);
    check_frame_a("t3r", base);
    check_eq("t3r_starts", starts_a - sbase, exp_a.size());
    @(negedge clk);
    bus_a.activate = 1'b0;

    // 2: 256-sample frame with mem[i]=i
    @(negedge clk);
    bus_b.activate = 1'b1;
    k = 0;
    while (bus_b.done !== 1'b1 && k < 20000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_eq("t2_done_seen", {31'd0, bus_b.done}, 32'd1);
`ifdef SAMPLE_READER_CHECKSUM_EN
    check_eq("t2_len", q_b.size(), 259);
    // sum 0..255 = 0x7F80 -> low byte 0x80, complement 0x80
    check_eq("t2_csum", {24'd0, q_b[258]}, 32'h0000_0080);
`else
    check_eq("t2_len", q_b.size(), 258);
`endif
    check_eq("t2_hdr", {24'd0, q_b[0]}, 32'h0000_00A5);
    check_eq("t2_lenbyte", {24'd0, q_b[1]}, 32'h0000_00FF);
    for (int i = 0; i < 256; i++) begin
      check_eq($sformatf("t2_s%0d", i), {24'd0, q_b[2 + i]}, i);
    end
    check_eq("t2_starts", starts_b, q_b.size());
    @(negedge clk);
    bus_b.activate = 1'b0;
    cycles(2);
    check_eq("t2_done_drop", {31'd0, bus_b.done}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
